// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite word-addressed SRAM responder with wait states and ERROR response
//
// Purpose: word-addressed SRAM target on the slave side of the interconnect.
//   It decodes address phases and stretches every OKAY data phase by WAIT_STATES cycles.
//   It returns read data or commits write data at the end of the data phase.
//   Illegal accesses (misaligned, non-word size, outside the window) get the two-cycle
//   ERROR response and never touch the array.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   S_HSel         slave select from the address decoder
//   S_HAddr        byte address (address phase)
//   S_HTrans       IDLE=00 BUSY=01 NON_SEQ=10 SEQ=11
//   S_HWrite       1=write, 0=read (address phase)
//   S_HSize        transfer size, only 3'b010 (word) is legal
//   S_HReady       bus HREADY, previous transfer complete
//   S_HWData       write data (data phase)
//   S_HRData       read data, non-zero only in a read DATA cycle
//   S_HReadyOut    0 extends the current data phase
//   S_HResp        00 OKAY, 01 ERROR
//   err_pulse      one-cycle pulse on the first ERROR cycle
module ahb_slave_mem #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_HSel,
  input  logic [ADDR_W-1:0] S_HAddr,
  input  logic [1:0]        S_HTrans,
  input  logic              S_HWrite,
  input  logic [2:0]        S_HSize,
  input  logic              S_HReady,
  input  logic [DATA_W-1:0] S_HWData,
  output logic [DATA_W-1:0] S_HRData,
  output logic              S_HReadyOut,
  output logic [1:0]        S_HResp,
  output logic              err_pulse
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Window size in bytes, one bit wider than the address so the bound never wraps.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH) << 2;
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              write_q, write_d;
  logic              valid_q, valid_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   offset;
  logic              trans_active;
  logic              accept_state;
  logic              capture;
  logic              illegal;
  logic              mem_we;

  // Address decode for the phase currently on the bus.
  always_comb begin
    offset       = {1'b0, S_HAddr} - {1'b0, BASE_ADDR};
    trans_active = (S_HTrans == 2'b10) || (S_HTrans == 2'b11);
    // A new address phase is only accepted while this slave drives ready high.
    accept_state = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    capture      = accept_state && S_HSel && S_HReady && trans_active;
    illegal      = (S_HAddr[1:0] != 2'b00) || (S_HSize != 3'b010) ||
                   (S_HAddr < BASE_ADDR) || (offset >= LIMIT);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    valid_d = valid_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 share the capture rules; DATA pipelines the next phase.
        state_d = ST_IDLE;
        valid_d = 1'b0;
        cnt_d   = 4'd0;
        if (capture) begin
          idx_d   = offset[IDX_W+1:2];
          write_d = S_HWrite;
          if (illegal) begin
            state_d = ST_ERR1;
          end else begin
            valid_d = 1'b1;
            if (WAIT_STATES == 0) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WS_INIT;
            end
          end
        end
      end
    endcase
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    S_HReadyOut = 1'b1;
    S_HResp     = 2'b00;
    err_pulse   = 1'b0;
    S_HRData    = '0;
    mem_we      = 1'b0;
    case (state_q)
      ST_WAIT: S_HReadyOut = 1'b0;
      ST_ERR1: begin
        S_HReadyOut = 1'b0;
        S_HResp     = 2'b01;
        err_pulse   = 1'b1;
      end
      ST_ERR2: S_HResp = 2'b01;
      ST_DATA: begin
        if (valid_q) begin
          if (write_q) mem_we   = 1'b1;
          else         S_HRData = mem[idx_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      valid_q <= valid_d;
    end
  end

  // Array is not reset; reset forces IDLE, so no write can commit while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= S_HWData;
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - randomized self-checking bench for ahb_slave_mem (WAIT_STATES 1 and 0)
module tb_ahb_slave_mem;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [31:0] hwdata = '0;
  int          dut = 0;  // 0: instance with WAIT_STATES=1, 1: instance with WAIT_STATES=0

  logic [31:0] rd_a, rd_b;
  logic        ro_a, ro_b, ep_a, ep_b;
  logic [1:0]  rs_a, rs_b;
  logic        hready_bus, ready, errp;
  logic [1:0]  resp;
  logic [31:0] rdata;

  assign hready_bus = (dut == 0) ? ro_a : ro_b;
  assign ready      = hready_bus;
  assign resp       = (dut == 0) ? rs_a : rs_b;
  assign rdata      = (dut == 0) ? rd_a : rd_b;
  assign errp       = (dut == 0) ? ep_a : ep_b;

  always #5 clk = ~clk;

  ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst(rst), .S_HSel(hsel && (dut == 0)), .S_HAddr(haddr), .S_HTrans(htrans),
    .S_HWrite(hwrite), .S_HSize(hsize), .S_HReady(hready_bus), .S_HWData(hwdata),
    .S_HRData(rd_a), .S_HReadyOut(ro_a), .S_HResp(rs_a), .err_pulse(ep_a));

  ahb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst(rst), .S_HSel(hsel && (dut == 1)), .S_HAddr(haddr), .S_HTrans(htrans),
    .S_HWrite(hwrite), .S_HSize(hsize), .S_HReady(hready_bus), .S_HWData(hwdata),
    .S_HRData(rd_b), .S_HReadyOut(ro_b), .S_HResp(rs_b), .err_pulse(ep_b));

  // Reference model: one word array per instance plus a written-yet flag.
  logic [31:0] ref_mem [2][DEPTH];
  bit          known   [2][DEPTH];
  int          checks = 0;
  int          errors = 0;

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
    return (a[1:0] == 2'b00) && (s == 3'b010) && (a < DEPTH * 4);
  endfunction

  // Expected outcome of one isolated transfer on the current instance; updates the model.
  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] wdata, output int e_wait, output logic [31:0] e_rd,
                            output logic [1:0] e_resp, output bit e_known);
    bit legal;
    int idx;
    legal   = is_legal(addr, size);
    e_wait  = legal ? ws_of(dut) : 1;
    e_resp  = legal ? 2'b00 : 2'b01;
    e_rd    = '0;
    e_known = 1'b1;
    if (legal) begin
      idx = int'(addr >> 2);
      if (wr) begin
        ref_mem[dut][idx] = wdata;
        known[dut][idx]   = 1'b1;
      end else begin
        e_rd    = ref_mem[dut][idx];
        e_known = known[dut][idx];
      end
    end
  endtask

  // One non-pipelined transfer; entered and left at posedge+1 with the bus idle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output int nwait, output logic [31:0] rdv,
                      output logic [1:0] resp_w, output logic [1:0] resp_d,
                      output logic ep0, output logic ep_late);
    bit done;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size; hwdata = $urandom;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwrite = 1'($urandom); hsize = 3'b010;
    nwait = 0; rdv = '0; resp_w = 2'b00; resp_d = 2'b11; ep0 = errp; ep_late = 1'b0; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) ep_late = ep_late | errp;
      if (ready) begin
        hwdata = wdata; rdv = rdata; resp_d = resp; done = 1'b1;
      end else begin
        hwdata = $urandom; nwait++; resp_w = resp_w | resp;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    if (!done) nwait = -1;
  endtask

  task automatic test_reset();
    checks++; if (ro_a !== 1'b1 || ro_b !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", ro_a, ro_b); end
    checks++; if (rs_a !== 2'b00 || rs_b !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b/%b expected 00/00", rs_a, rs_b); end
    checks++; if (rd_a !== 32'h0 || rd_b !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", rd_a, rd_b); end
    checks++; if (ep_a !== 1'b0 || ep_b !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b/%b expected 0/0", ep_a, ep_b); end
  endtask

  task automatic test_write_read();
    int nw, ew; logic [31:0] rv, er; logic [1:0] rw, rdp, eresp; logic e0, el; bit ek;
    dut = 0;
    model_xfer(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, ew, er, eresp, ek);
    xfer(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, nw, rv, rw, rdp, e0, el);
    checks++; if (nw !== 1 || rdp !== 2'b00) begin errors++; $display("FAIL wr_phase: got wait=%0d resp=%b expected wait=1 resp=00", nw, rdp); end
    model_xfer(1'b0, 32'h10, 3'b010, 32'h0, ew, er, eresp, ek);
    xfer(1'b0, 32'h10, 3'b010, 32'h0, nw, rv, rw, rdp, e0, el);
    checks++; if (nw !== 1 || rdp !== 2'b00 || rw !== 2'b00) begin errors++; $display("FAIL rd_phase: got wait=%0d resp=%b/%b expected wait=1 resp=00", nw, rw, rdp); end
    checks++; if (rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rv); end
  endtask

  task automatic test_burst();
    int nw, ew; logic [31:0] rv, er; logic [1:0] rw, rdp, eresp; logic e0, el; bit ek;
    dut = 1;
    for (int b = 0; b < 4; b++) begin
      model_xfer(1'b1, 32'(b * 4), 3'b010, 32'(b + 1), ew, er, eresp, ek);
      xfer(1'b1, 32'(b * 4), 3'b010, 32'(b + 1), nw, rv, rw, rdp, e0, el);
    end
    hsel = 1'b1; hwrite = 1'b0; hsize = 3'b010;
    for (int b = 0; b <= 4; b++) begin
      if (b < 4) begin
        htrans = (b == 0) ? 2'b10 : 2'b11; haddr = 32'(b * 4);
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL burst_ready beat %0d: got %b expected 1", b, ready); end
      if (b > 0) begin
        checks++; if (rdata !== ref_mem[1][b-1]) begin errors++; $display("FAIL burst_data beat %0d: got %h expected %h", b - 1, rdata, ref_mem[1][b-1]); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_error();
    int nw, ew; logic [31:0] rv, er; logic [1:0] rw, rdp, eresp; logic e0, el; bit ek;
    logic [31:0] addrs [4];
    logic [2:0]  sizes [4];
    bit          wrs   [4];
    addrs = '{DEPTH * 4, 32'h2, 32'h0, 32'hFFFF_FFFC};
    sizes = '{3'b010, 3'b010, 3'b000, 3'b010};
    wrs   = '{1'b0, 1'b1, 1'b1, 1'b1};
    for (int d = 0; d < 2; d++) begin
      dut = d;
      model_xfer(1'b1, 32'h0, 3'b010, 32'hA5A5_0000 + 32'(d), ew, er, eresp, ek);
      xfer(1'b1, 32'h0, 3'b010, 32'hA5A5_0000 + 32'(d), nw, rv, rw, rdp, e0, el);
      for (int k = 0; k < 4; k++) begin
        model_xfer(wrs[k], addrs[k], sizes[k], $urandom, ew, er, eresp, ek);
        xfer(wrs[k], addrs[k], sizes[k], 32'h1234_5678, nw, rv, rw, rdp, e0, el);
        checks++; if (nw !== 1 || rw !== 2'b01 || rdp !== 2'b01) begin errors++; $display("FAIL err_resp dut%0d case%0d: got wait=%0d resp=%b/%b expected 1 01/01", d, k, nw, rw, rdp); end
        checks++; if (e0 !== 1'b1 || el !== 1'b0) begin errors++; $display("FAIL err_pulse dut%0d case%0d: got %b/%b expected 1/0", d, k, e0, el); end
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL err_rdata dut%0d case%0d: got %h expected 0", d, k, rv); end
      end
      model_xfer(1'b0, 32'h0, 3'b010, 32'h0, ew, er, eresp, ek);
      xfer(1'b0, 32'h0, 3'b010, 32'h0, nw, rv, rw, rdp, e0, el);
      checks++; if (rv !== er) begin errors++; $display("FAIL err_no_write dut%0d: got %h expected %h", d, rv, er); end
    end
  endtask

  task automatic test_idle_busy();
    int nw, ew; logic [31:0] rv, er; logic [1:0] rw, rdp, eresp; logic e0, el; bit ek;
    dut = 0;
    model_xfer(1'b1, 32'h14, 3'b010, 32'h0BAD_F00D, ew, er, eresp, ek);
    xfer(1'b1, 32'h14, 3'b010, 32'h0BAD_F00D, nw, rv, rw, rdp, e0, el);
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       begin hsel = 1'b1; htrans = 2'b01; end
        1:       begin hsel = 1'b1; htrans = 2'b00; end
        default: begin hsel = 1'b0; htrans = 2'b10; end
      endcase
      hwrite = 1'b1; haddr = 32'h14; hwdata = $urandom;
      @(posedge clk); #1;
      checks++; if (ready !== 1'b1 || resp !== 2'b00) begin errors++; $display("FAIL idle_busy cycle %0d: got ready=%b resp=%b expected 1 00", i, ready, resp); end
    end
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    @(posedge clk); #1;
    model_xfer(1'b0, 32'h14, 3'b010, 32'h0, ew, er, eresp, ek);
    xfer(1'b0, 32'h14, 3'b010, 32'h0, nw, rv, rw, rdp, e0, el);
    checks++; if (rv !== er) begin errors++; $display("FAIL idle_busy_nowrite: got %h expected %h", rv, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, dv;
    int nw;
    bit done;
    for (int d = 0; d < 2; d++) begin
      dut = d;
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      dv = $urandom;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a; hsize = 3'b010;
      @(posedge clk); #1;
      hwrite = 1'b0; hwdata = dv; done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        if (ready) done = 1'b1;
        @(posedge clk); #1;
      end
      hsel = 1'b0; htrans = 2'b00; hwdata = $urandom; nw = 0;
      for (int i = 0; i < 20 && !ready; i++) begin
        nw++; @(posedge clk); #1;
      end
      ref_mem[d][a >> 2] = dv; known[d][a >> 2] = 1'b1;
      checks++; if (nw !== ws_of(d) || ready !== 1'b1) begin errors++; $display("FAIL b2b_wait dut%0d: got %0d expected %0d", d, nw, ws_of(d)); end
      checks++; if (rdata !== dv) begin errors++; $display("FAIL b2b_raw dut%0d: got %h expected %h", d, rdata, dv); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int nw, ew; logic [31:0] rv, er; logic [1:0] rw, rdp, eresp; logic e0, el; bit ek;
    dut = 0;
    model_xfer(1'b1, 32'h8, 3'b010, 32'h5555_AAAA, ew, er, eresp, ek);
    xfer(1'b1, 32'h8, 3'b010, 32'h5555_AAAA, nw, rv, rw, rdp, e0, el);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid_wait: got ready=%b expected 0", ready); end
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_0000;
    #2 rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || resp !== 2'b00 || rdata !== 32'h0 || errp !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got ready=%b resp=%b rdata=%h err=%b expected 1 00 0 0", ready, resp, rdata, errp); end
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    model_xfer(1'b0, 32'h8, 3'b010, 32'h0, ew, er, eresp, ek);
    xfer(1'b0, 32'h8, 3'b010, 32'h0, nw, rv, rw, rdp, e0, el);
    checks++; if (rv !== 32'h5555_AAAA) begin errors++; $display("FAIL rst_mid_mem: got %h expected 5555aaaa", rv); end
  endtask

  task automatic test_random();
    int nw, ew; logic [31:0] rv, er; logic [1:0] rw, rdp, eresp; logic e0, el; bit ek;
    logic [31:0] a, wd; logic [2:0] sz; bit wr; bit legal;
    for (int n = 0; n < 80; n++) begin
      dut = int'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        7:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        8:       a = 32'(DEPTH * 4) + (32'($urandom_range(0, 63)) << 2);
        9:       a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        default: a = 32'($urandom_range(0, 15)) << 2;
      endcase
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      wr = 1'($urandom); wd = $urandom;
      legal = is_legal(a, sz);
      model_xfer(wr, a, sz, wd, ew, er, eresp, ek);
      xfer(wr, a, sz, wd, nw, rv, rw, rdp, e0, el);
      checks++; if (nw !== ew || rdp !== eresp || rw !== (legal ? 2'b00 : 2'b01)) begin errors++; $display("FAIL rand_resp #%0d dut%0d addr %h: got wait=%0d resp=%b/%b expected wait=%0d resp=%b", n, dut, a, nw, rw, rdp, ew, eresp); end
      checks++; if (e0 !== !legal || el !== 1'b0) begin errors++; $display("FAIL rand_err_pulse #%0d: got %b/%b expected %b/0", n, e0, el, !legal); end
      if (ek) begin
        checks++; if (rv !== er) begin errors++; $display("FAIL rand_rdata #%0d dut%0d addr %h: got %h expected %h", n, dut, a, rv, er); end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_write_read();
    test_burst();
    test_error();
    test_idle_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
